// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator CPU core.
//   opcode_e  : 4-bit instruction opcodes (direct-mode meaning)
//   state_e   : sequencer states
//   skip_e    : SKIP condition codes held in IR[11:10]
//   alu_op_e  : ALU operation select
package acc_cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_HALT  = 4'd1,
    OP_LOAD  = 4'd2,
    OP_STORE = 4'd3,
    OP_CLEAR = 4'd4,
    OP_SKIP  = 4'd5,
    OP_JUMP  = 4'd6,
    OP_SUB   = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_NOT   = 4'd10
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_IR,
    S_EXEC,
    S_MEM_RD,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    SK_NEG   = 2'b00,
    SK_ZERO  = 2'b01,
    SK_POS   = 2'b10,
    SK_NEVER = 2'b11
  } skip_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOT,
    ALU_PASS
  } alu_op_e;

  // Direct opcodes that touch memory in EXEC (reads plus STORE).
  function automatic logic is_mem_op(input logic [3:0] opc);
    return opc inside {OP_ADD, OP_LOAD, OP_STORE, OP_SUB, OP_AND, OP_OR};
  endfunction

  // Opcodes that combine acc with an operand; used for immediates.
  function automatic logic is_alu_op(input logic [3:0] opc);
    return opc inside {OP_ADD, OP_LOAD, OP_SUB, OP_AND, OP_OR};
  endfunction

  function automatic alu_op_e alu_sel(input logic [3:0] opc);
    alu_op_e sel;
    case (opc)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_NOT:  sel = ALU_NOT;
      default: sel = ALU_PASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU.
//   op_i : operation select
//   a_i  : accumulator operand
//   b_i  : memory/immediate operand
//   y_o  : result (wraps modulo 2^DATA_WIDTH)
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  alu_op_e               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] y_o
);

  always_comb begin
    y_o = b_i;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_NOT:  y_o = ~a_i;
      default:  y_o = b_i;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU with a synchronous single-port memory.
//   clk, rst (async, active-high), start (pulse, honoured only in IDLE)
//   mem_addr/mem_wdata/mem_cs/mem_we/mem_oe : memory request, registered
//   mem_rdata : read data, valid the cycle after a read request
//   acc, pc, busy, halted, retired : architectural state and status
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned RESET_PC   = 'h100,
  parameter int unsigned PC_STEP    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic [31:0]           retired
);

  localparam logic [ADDR_WIDTH-1:0] PC_INC  = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, ir_q, ir_d, mem_wdata_q, mem_wdata_d;
  logic [31:0]           ret_q, ret_d;
  logic                  mem_cs_q, mem_cs_d, mem_we_q, mem_we_d, mem_oe_q;
  logic                  busy_q, halted_q;

  logic                  ir_imm;
  logic [3:0]            ir_opc;
  logic [DATA_WIDTH-1:0] ir_opnd;
  logic [3:0]            nxt_opc;
  logic                  skip_take;
  alu_op_e               alu_op;
  logic [DATA_WIDTH-1:0] alu_b, alu_y;

  assign ir_imm  = ir_q[DATA_WIDTH-1];
  assign ir_opc  = ir_q[DATA_WIDTH-2 -: 4];
  assign ir_opnd = {5'b0, ir_q[DATA_WIDTH-6:0]};
  assign nxt_opc = ir_d[DATA_WIDTH-2 -: 4];

  assign alu_op = alu_sel(ir_opc);
  assign alu_b  = (state_q == S_MEM_RD) ? mem_rdata : ir_opnd;

  acc_cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op_i (alu_op),
    .a_i  (acc_q),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  always_comb begin
    skip_take = 1'b0;
    case (ir_q[11:10])
      SK_NEG:  skip_take = acc_q[DATA_WIDTH-1];
      SK_ZERO: skip_take = (acc_q == '0);
      SK_POS:  skip_take = !acc_q[DATA_WIDTH-1] && (acc_q != '0);
      default: skip_take = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   state_d = S_LOAD_IR;
      S_LOAD_IR: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + PC_INC;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        ret_d   = ret_q + 32'd1;
        if (ir_imm) begin
          if (is_alu_op(ir_opc)) acc_d = alu_y;
        end else begin
          case (ir_opc)
            OP_ADD, OP_LOAD, OP_SUB, OP_AND, OP_OR: begin
              state_d = S_MEM_RD;
              ret_d   = ret_q;
            end
            OP_HALT:  state_d = S_HALT;
            OP_CLEAR: acc_d = '0;
            OP_NOT:   acc_d = alu_y;
            OP_SKIP:  if (skip_take) pc_d = pc_q + PC_INC;
            OP_JUMP:  pc_d = ir_q[ADDR_WIDTH-1:0];
            default:  ;
          endcase
        end
      end
      S_MEM_RD: begin
        acc_d   = alu_y;
        ret_d   = ret_q + 32'd1;
        state_d = S_FETCH;
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase

    // Memory outputs are registered, so they are derived from the state being
    // entered; the EXEC request decodes the instruction word arriving in ir_d.
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == S_FETCH) begin
      mem_cs_d   = 1'b1;
      mem_addr_d = pc_d;
    end else if (state_d == S_EXEC && !ir_d[DATA_WIDTH-1] && is_mem_op(nxt_opc)) begin
      mem_cs_d   = 1'b1;
      mem_addr_d = ir_d[ADDR_WIDTH-1:0];
      if (nxt_opc == OP_STORE) begin
        mem_we_d    = 1'b1;
        mem_wdata_d = acc_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_INIT;
      acc_q       <= '0;
      ir_q        <= '0;
      ret_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      ir_q        <= ir_d;
      ret_q       <= ret_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_cs_d & ~mem_we_d;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q    <= (state_d == S_HALT);
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign retired   = ret_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
module tb_acc_cpu_core;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 14;
  localparam int unsigned MSZ = 16384;

  logic          clk, rst, start;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata, acc;
  logic          mem_cs, mem_we, mem_oe, busy, halted;
  logic [31:0]   retired;

  acc_cpu_core #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESET_PC   ('h100),
    .PC_STEP    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .acc       (acc),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory; img is copied in while ld_req is high.
  logic [31:0] mem [0:MSZ-1];
  logic [31:0] img [0:MSZ-1];
  logic [31:0] refm[0:MSZ-1];
  logic        ld_req;

  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < MSZ; i++) mem[i] <= img[i];
    end else if (mem_cs && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_cs && !mem_we) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } st_t;

  typedef struct {
    logic [31:0] acc;
    logic [13:0] pc;
    logic [31:0] ret;
    int unsigned cyc;
  } fin_t;

  st_t  exp_st[$];
  fin_t exp_fin[$];
  fin_t exp_last;
  int   checks   = 0;
  int   failures = 0;
  logic mon_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] ins(input bit imm, input int unsigned opc, input int unsigned opd);
    return {imm, opc[3:0], opd[26:0]};
  endfunction

  // Instruction-level reference: interprets the program in refm one
  // instruction at a time and records every store plus the final state.
  task automatic ref_run(output bit ok);
    logic [31:0] a, w, opd;
    logic [13:0] p, ea;
    int unsigned ret, cyc;
    bit          done, take;
    st_t         loc[$];
    fin_t        f;
    a = 0; p = 14'h100; ret = 0; cyc = 0; done = 0;
    for (int s = 0; s < 400 && !done; s++) begin
      w   = refm[p];
      p   = p + 14'd2;
      opd = {5'b0, w[26:0]};
      ea  = w[13:0];
      ret++;
      cyc += 3;
      if (w[31]) begin
        case (w[30:27])
          4'd0: a = a + opd;
          4'd2: a = opd;
          4'd7: a = a - opd;
          4'd8: a = a & opd;
          4'd9: a = a | opd;
          default: ;
        endcase
      end else begin
        case (w[30:27])
          4'd0:  begin a = a + refm[ea]; cyc++; end
          4'd1:  done = 1;
          4'd2:  begin a = refm[ea];     cyc++; end
          4'd3:  begin refm[ea] = a; loc.push_back('{ea, a}); end
          4'd4:  a = 0;
          4'd5:  begin
            case (w[11:10])
              2'd0:    take = $signed(a) < 0;
              2'd1:    take = (a == 0);
              2'd2:    take = $signed(a) > 0;
              default: take = 0;
            endcase
            if (take) p = p + 14'd2;
          end
          4'd6:  p = ea;
          4'd7:  begin a = a - refm[ea]; cyc++; end
          4'd8:  begin a = a & refm[ea]; cyc++; end
          4'd9:  begin a = a | refm[ea]; cyc++; end
          4'd10: a = ~a;
          default: ;
        endcase
      end
    end
    ok = done;
    if (ok) begin
      foreach (loc[i]) exp_st.push_back(loc[i]);
      f.acc = a; f.pc = p; f.ret = ret; f.cyc = cyc;
      exp_fin.push_back(f);
      exp_last = f;
    end
  endtask

  task automatic prep_model(output bit ok);
    for (int i = 0; i < MSZ; i++) refm[i] = img[i];
    ref_run(ok);
  endtask

  task automatic clr_img();
    for (int i = 0; i < MSZ; i++) img[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
    chk("rst_pc",     pc,        32'h100);
    chk("rst_acc",    acc,       32'h0);
    chk("rst_ret",    retired,   32'h0);
    chk("rst_busy",   busy,      32'h0);
    chk("rst_halted", halted,    32'h0);
    chk("rst_cs",     mem_cs,    32'h0);
    chk("rst_we",     mem_we,    32'h0);
    chk("rst_oe",     mem_oe,    32'h0);
    chk("rst_addr",   mem_addr,  32'h0);
    chk("rst_wdata",  mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int unsigned fgap;

  task automatic run_dut(input bit with_rst, input bit extra_start);
    int unsigned n, nf, f1, f2;
    if (with_rst) do_reset();
    mon_en = 1'b1;
    nf = 0; f1 = 0; f2 = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!halted && n < 4000) begin
      if (mem_cs && !mem_we && mem_addr == pc) begin
        if (nf == 0) f1 = n;
        else if (nf == 1) f2 = n;
        nf++;
      end
      @(negedge clk);
      n++;
      start = extra_start && (n == 5);
    end
    fgap = f2 - f1;
    if (!halted) begin
      checks++; failures++;
      $display("FAIL halt_timeout: actual=not_halted required=halted");
      exp_st.delete(); exp_fin.delete();
      mon_en = 1'b0;
      return;
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("halt_hold",     halted,  32'h1);
    chk("halt_ret_hold", retired, exp_last.ret);
    chk("halt_pc_hold",  pc,      {18'h0, exp_last.pc});
    mon_en = 1'b0;
    chk("st_left",  exp_st.size(),  32'h0);
    chk("fin_left", exp_fin.size(), 32'h0);
  endtask

  // Monitor: compares every store and the halt state against the scoreboard.
  initial begin : monitor
    bit          hs;
    int unsigned bc;
    st_t         s;
    fin_t        f;
    hs = 0; bc = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hs = 0; bc = 0;
      end else begin
        if (busy) bc++;
        chk("oe_decode", mem_oe, mem_cs & ~mem_we);
        if (!busy) chk("idle_cs", mem_cs, 32'h0);
        if (mem_cs && mem_we) begin
          if (exp_st.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_store: actual addr=0x%0h data=0x%0h required=no store", mem_addr, mem_wdata);
          end else begin
            s = exp_st.pop_front();
            chk("st_addr", mem_addr,  s.addr);
            chk("st_data", mem_wdata, s.data);
          end
        end
        if (halted && !hs) begin
          hs = 1;
          if (exp_fin.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_halt: actual=halted required=running");
          end else begin
            f = exp_fin.pop_front();
            chk("fin_acc",    acc,     f.acc);
            chk("fin_pc",     pc,      f.pc);
            chk("fin_ret",    retired, f.ret);
            chk("fin_cycles", bc,      f.cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit          ok, md;
    int unsigned op, od, n, L, sel;
    rst = 1'b1; start = 1'b0; ld_req = 1'b0; mon_en = 1'b0;
    L = 16;

    // LOAD/ADD/STORE/HALT
    clr_img();
    img['h11A] = 32'd5; img['h11C] = 32'd7; img['h11E] = 32'hDEADBEEF;
    img['h100] = ins(0, 2, 'h11A);
    img['h102] = ins(0, 0, 'h11C);
    img['h104] = ins(0, 3, 'h11E);
    img['h106] = ins(0, 1, 0);
    prep_model(ok);
    run_dut(1, 0);
    chk("r037_mem", mem['h11E], 32'd12);
    chk("r037_pc",  pc,         32'h108);
    chk("r037_ret", retired,    32'd4);
    chk("r037_lat", fgap,       32'd4);

    // Reset during the STORE cycle, then re-run the same program
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(mem_cs && mem_we) && n < 100) begin @(negedge clk); n++; end
    if (!(mem_cs && mem_we)) begin
      checks++; failures++;
      $display("FAIL abort_store_wait: actual=no store required=store");
    end else begin
      rst = 1'b1;
      #1;
      chk("abort_pc",   pc,     32'h100);
      chk("abort_busy", busy,   32'h0);
      chk("abort_cs",   mem_cs, 32'h0);
      chk("abort_we",   mem_we, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_mem", mem['h11E], 32'hDEADBEEF);
      prep_model(ok);
      run_dut(0, 0);
      chk("rerun_mem", mem['h11E], 32'd12);
    end

    // Immediates and SKIP on negative
    clr_img();
    img['h100] = ins(1, 2, 3);
    img['h102] = ins(1, 7, 5);
    img['h104] = ins(0, 5, 0 << 10);
    img['h106] = ins(0, 4, 0);
    img['h108] = ins(0, 1, 0);
    prep_model(ok);
    run_dut(1, 0);
    chk("r038_acc", acc,     32'hFFFFFFFE);
    chk("r038_ret", retired, 32'd4);

    // JUMP
    clr_img();
    img['h100] = ins(0, 6, 'h200);
    img['h200] = ins(0, 1, 0);
    prep_model(ok);
    run_dut(1, 0);
    chk("r039_pc",  pc,   32'h202);
    chk("r039_lat", fgap, 32'd3);

    // Unassigned direct opcode
    clr_img();
    img['h100] = ins(0, 13, 'h55);
    img['h102] = ins(0, 1, 0);
    prep_model(ok);
    run_dut(1, 0);
    chk("r040_acc", acc,     32'h0);
    chk("r040_ret", retired, 32'd2);

    // 7*9 by repeated addition
    clr_img();
    img['h300] = 32'd7; img['h302] = 32'd9; img['h304] = 32'd0;
    img['h100] = ins(0, 2, 'h302);
    img['h102] = ins(0, 5, 1 << 10);
    img['h104] = ins(0, 6, 'h108);
    img['h106] = ins(0, 1, 0);
    img['h108] = ins(1, 7, 1);
    img['h10A] = ins(0, 3, 'h302);
    img['h10C] = ins(0, 2, 'h304);
    img['h10E] = ins(0, 0, 'h300);
    img['h110] = ins(0, 3, 'h304);
    img['h112] = ins(0, 6, 'h100);
    prep_model(ok);
    run_dut(1, 0);
    chk("r042_prod", mem['h304], 32'd63);
    chk("r042_halt", halted,     32'h1);

    // Random forward-flowing programs
    for (int t = 0; t < 30; t++) begin
      ok = 0;
      while (!ok) begin
        clr_img();
        for (int i = 0; i < 16; i++) begin
          sel = $urandom_range(0, 3);
          case (sel)
            0:       img['h300 + i] = 32'h0;
            1:       img['h300 + i] = $urandom;
            2:       img['h300 + i] = $urandom_range(0, 20);
            default: img['h300 + i] = -$urandom_range(1, 20);
          endcase
        end
        for (int i = 0; i < int'(L); i++) begin
          md = 1'($urandom_range(0, 1));
          op = $urandom_range(0, 15);
          if (!md && op == 1 && $urandom_range(0, 3) != 0) op = 0;
          if (!md && op == 6)
            od = 'h100 + 2 * $urandom_range(i + 1, L);
          else if (!md && (op == 0 || op == 2 || op == 3 || op == 7 || op == 8 || op == 9))
            od = ($urandom & 'h7FFC000) | ('h300 + $urandom_range(0, 15));
          else
            od = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 31) : $urandom;
          img['h100 + 2 * i] = ins(md, op, od);
        end
        img['h100 + 2 * L]     = ins(0, 1, 0);
        img['h100 + 2 * L + 2] = ins(0, 1, 0);
        prep_model(ok);
      end
      run_dut(1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
